i2c_rx_timer: RTL

- Bit-timing and receive stage directly upstream of the I2C slave main controller.
- Tracks synchronized SCL edges, shifts SDA into an 8-bit receive register (MSB first), and counts bits within each 9-clock I2C frame (8 data + ACK).
- Produces the rx_data, byte_received, ack_prep, ack_check and ack_done strobes that the controller consumes.

---
 rtl/i2c_rx_timer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/i2c_rx_timer.sv
// i2c_rx_timer: SCL edge tracking, MSB-first SDA receive register and
// 9-clock frame bit counter feeding the I2C slave main controller.
// Optional build macro SCL_FILTER_EN adds a FILTER_CYCLES-deep SCL glitch filter.

module i2c_rx_timer #(
    parameter int FILTER_CYCLES = 2
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       SCL_sync,
    input  logic       SDA_sync,
    input  logic       start,
    input  logic       stop,
    input  logic       rx_enable,
    output logic [7:0] rx_data,
    output logic       byte_received,
    output logic       ack_prep,
    output logic       ack_check,
    output logic       ack_done,
    output logic       scl_rise,
    output logic       scl_fall
);

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        WAIT_ACK_FALL,
        WAIT_ACK_RISE,
        WAIT_ACK_END
    } state_t;

    state_t     state_q;
    logic [3:0] bit_cnt_q;
    logic [7:0] rx_data_q;
    logic       scl_prev_q;
    logic       scl_acc;
    logic       byte_received_q;
    logic       ack_prep_q;
    logic       ack_check_q;
    logic       ack_done_q;
    logic       scl_rise_q;
    logic       scl_fall_q;
    logic       rise_c;
    logic       fall_c;
    logic       edge_ok;

`ifdef SCL_FILTER_EN
    localparam int CntW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;

    logic [CntW-1:0] filt_cnt_q;
    logic            scl_filt_q;

    // Accept a new SCL level only after it has persisted for FILTER_CYCLES clocks.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            filt_cnt_q <= '0;
            scl_filt_q <= 1'b1;
        end else if (SCL_sync == scl_filt_q) begin
            filt_cnt_q <= '0;
        end else if (filt_cnt_q == CntW'(FILTER_CYCLES - 1)) begin
            scl_filt_q <= SCL_sync;
            filt_cnt_q <= '0;
        end else begin
            filt_cnt_q <= filt_cnt_q + 1'b1;
        end
    end

    assign scl_acc = scl_filt_q;
`else
    // FILTER_CYCLES only shapes the optional filter; the raw level is used here.
    if (FILTER_CYCLES < 1) begin : g_filter_cycles_unused
    end

    assign scl_acc = SCL_sync;
`endif

    assign rise_c  = scl_acc & ~scl_prev_q;
    assign fall_c  = ~scl_acc & scl_prev_q;
    assign edge_ok = (state_q != IDLE) && !start && !stop;

    // Previous accepted SCL level; resets high so releasing reset is not an edge.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            scl_prev_q <= 1'b1;
        end else begin
            scl_prev_q <= scl_acc;
        end
    end

    // Frame FSM: shifts data, counts bits and issues one-cycle registered strobes.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q         <= IDLE;
            bit_cnt_q       <= 4'd0;
            rx_data_q       <= 8'h00;
            byte_received_q <= 1'b0;
            ack_prep_q      <= 1'b0;
            ack_check_q     <= 1'b0;
            ack_done_q      <= 1'b0;
            scl_rise_q      <= 1'b0;
            scl_fall_q      <= 1'b0;
        end else begin
            byte_received_q <= 1'b0;
            ack_prep_q      <= 1'b0;
            ack_check_q     <= 1'b0;
            ack_done_q      <= 1'b0;
            scl_rise_q      <= rise_c & edge_ok;
            scl_fall_q      <= fall_c & edge_ok;
            if (stop) begin
                state_q   <= IDLE;
                bit_cnt_q <= 4'd0;
            end else if (start) begin
                state_q   <= DATA;
                bit_cnt_q <= 4'd0;
            end else begin
                case (state_q)
                    DATA: begin
                        if (rise_c) begin
                            if (rx_enable) begin
                                rx_data_q <= {rx_data_q[6:0], SDA_sync};
                            end
                            if (bit_cnt_q == 4'd7) begin
                                bit_cnt_q       <= 4'd8;
                                byte_received_q <= 1'b1;
                                state_q         <= WAIT_ACK_FALL;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 4'd1;
                            end
                        end
                    end
                    WAIT_ACK_FALL: begin
                        if (fall_c) begin
                            ack_prep_q <= 1'b1;
                            state_q    <= WAIT_ACK_RISE;
                        end
                    end
                    WAIT_ACK_RISE: begin
                        if (rise_c) begin
                            ack_check_q <= 1'b1;
                            bit_cnt_q   <= 4'd9;
                            state_q     <= WAIT_ACK_END;
                        end
                    end
                    WAIT_ACK_END: begin
                        if (fall_c) begin
                            ack_done_q <= 1'b1;
                            bit_cnt_q  <= 4'd0;
                            state_q    <= DATA;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign rx_data       = rx_data_q;
    assign byte_received = byte_received_q;
    assign ack_prep      = ack_prep_q;
    assign ack_check     = ack_check_q;
    assign ack_done      = ack_done_q;
    assign scl_rise      = scl_rise_q;
    assign scl_fall      = scl_fall_q;

endmodule
